// File: rtl/pipe_reg_chain_pkg.sv
// pipe_pkg: shared limits, occupancy-width helper and word payload type for
// the elastic pipeline register chain.
//   MAX_STAGES / MAX_WIDTH : supported parameter limits
//   occ_width()            : width of the occupancy counter for a given depth
//   pipe_word_t            : {valid, data} payload at the maximum width
package pipe_pkg;

    localparam int unsigned MAX_STAGES = 8;
    localparam int unsigned MAX_WIDTH  = 64;

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] data;
    } pipe_word_t;

    // Room for STAGES entries plus an optional skid entry, plus zero.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $unsigned($clog2(stages + 32'd2));
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one valid+data register of the chain.
//   clk, clr      : clock, asynchronous active-high reset
//   flush         : synchronous clear of the valid bit (data held)
//   load          : stage takes its source this cycle
//   src_valid/src_data : word offered by the previous stage or input
//   valid/data    : registered stage contents
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only moves with a valid source, so bubbles never overwrite it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready pipeline register, STAGES deep.
//   clk, clr            : clock, asynchronous active-high reset
//   in_valid/in_data    : upstream word, in_ready accepts it
//   out_valid/out_data  : last-stage word, out_ready consumes it
//   flush               : synchronous kill of every in-flight word
//   occupancy           : number of valid entries held
// Build option: define PIPE_REG_CHAIN_SKID_EN to add a one-entry skid buffer
// in front of stage 0, which registers in_ready and adds one entry of capacity.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      OCC_W     = occ_width(STAGES)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  d [STAGES];
    logic              s0_valid;
    logic [WIDTH-1:0]  s0_data;
    logic              in_fire;
    logic              out_fire;
    logic [OCC_W-1:0]  occ_q;

    // Stage i may advance if any later stage has a hole or the sink takes a word.
    for (genvar g = 0; g < STAGES; g++) begin : g_ready
        if (g == STAGES - 1) begin : g_last
            assign rdy[g] = out_ready;
        end else begin : g_inner
            assign rdy[g] = out_ready | ~(&v[STAGES-1:g+1]);
        end
    end

    assign ld = ~v | rdy;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        if (g == 0) begin : g_head
            assign src_valid = s0_valid;
            assign src_data  = s0_data;
        end else begin : g_body
            assign src_valid = v[g-1];
            assign src_data  = d[g-1];
        end
        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .clr       (clr),
            .flush     (flush),
            .load      (ld[g]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (v[g]),
            .data      (d[g])
        );
    end

`ifdef PIPE_REG_CHAIN_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Parks an accepted word when stage 0 is blocked; drains before new input.
    pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .load      (!skid_valid || ld[0]),
        .src_valid (!skid_valid && in_valid && !ld[0]),
        .src_data  (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    assign s0_valid = skid_valid | in_valid;
    assign s0_data  = skid_valid ? skid_data : in_data;
    assign in_ready = !skid_valid && !flush;
`else
    assign s0_valid = in_valid;
    assign s0_data  = in_data;
    assign in_ready = ld[0] && !flush;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = v[STAGES-1] && out_ready;

    // Running count of held words; flush empties the chain after any delivery.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end

    assign occupancy = occ_q;
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register that carries a WIDTH-bit word through STAGES register stages.
- Each stage has a valid bit, and a valid/ready handshake runs on both sides.
- Adds synchronous flush, occupancy count and reset-value control over a plain enable/clear register.
- Sits between processor pipeline stages (fetch/decode/execute/memory) and replaces hand-wired per-stage enable registers.

Parameters:
- WIDTH, 32, data word width in bits (1..64).
- STAGES, 2, number of register stages (1..8).
- RESET_VAL, 0, value loaded into every data register on clr (WIDTH bits).
- OCC_W, $clog2(STAGES+2), occupancy output width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- clr  input  1  reset; asynchronous, active-high.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  chain accepts in_data this cycle.
- out_valid  output  1  last stage holds a valid word.
- out_data  output  WIDTH  last stage data.
- out_ready  input  1  downstream consumes out_data this cycle.
- flush  input  1  synchronous kill of all in-flight words.
- occupancy  output  OCC_W  number of valid entries held.

Behaviour:
- Reset: clr=1 immediately clears all valid bits and sets all data registers to RESET_VAL. out_valid=0, out_data=RESET_VAL and occupancy=0 while clr is high. Deassertion takes effect at the next clk edge.
- Stage i (0 = input side, STAGES-1 = output side) holds v[i] and d[i].
- ready[STAGES-1] = out_ready. For i < STAGES-1, ready[i] = !v[i+1] || ready[i+1]; this is combinational back-propagation.
- Stage i loads when !v[i] || ready[i]. Source is the previous stage, or in_valid/in_data for stage 0.
- in_ready = (!v[0] || ready[0]) && !flush.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
- Data registers load only when their source is valid, so bubbles never overwrite data. A stage whose source is invalid clears its valid bit and holds its data.
- Throughput is one word per cycle when out_ready is held high.
- Latency: a word accepted at edge N appears on out_valid after edge N+STAGES-1. Stage 0 captures at edge N, so STAGES=1 gives out_valid in the cycle after acceptance.
- Full: all v=1 and out_ready=0. in_ready=0 and all contents hold.
- Empty: out_valid=0. out_data holds the last data value, not RESET_VAL.
- Simultaneous input and output transfers on a full chain: permitted. The chain shifts and occupancy is unchanged.
- flush=1 at an edge clears all valid bits; data is unchanged. in_ready=0 that cycle, so no word is accepted. out_valid remains as registered that cycle, and an output transfer in the flush cycle is legal and counts as delivered.
- flush together with clr: clr dominates.
- occupancy = popcount of the valid bits, plus the skid entry when that is compiled in. Updated every edge; never exceeds STAGES (+1).
- Word order is preserved. Nothing is duplicated or dropped except by flush or clr.

Optional Feature:
- Macro PIPE_REG_CHAIN_SKID_EN.
- Defined: adds a one-entry skid buffer before stage 0.
  - in_ready = !skid_valid && !flush, a registered value with no combinational path from out_ready.
  - If in_ready=1 and stage 0 cannot load, the word parks in the skid entry.
  - The skid entry drains into stage 0 before any new input is taken.
  - Capacity becomes STAGES+1. flush and clr also clear skid_valid.
- Undefined: no skid entry. in_ready is combinational as described above and capacity is STAGES.

Decomposition:
- Package pipe_pkg:
  - MAX_STAGES=8 and MAX_WIDTH=64 limit constants.
  - occ_width() function.
  - pipe_word_t struct {valid, data}; parametrised width is handled via WIDTH at use sites.
- One sub-module, pipe_stage: a single valid+data register with async clr, load enable and flush. Instantiate STAGES copies in a generate loop, plus one more for the skid entry.

Test Plan:
- Reset: clr pulse mid-stream with STAGES=2, RESET_VAL=32'hDEAD_BEEF -> same cycle out_valid=0, out_data=32'hDEADBEEF, occupancy=0; after release, 32'h1 accepted and appears after 2 edges.
- Streaming: out_ready=1, 10 words 0..9 pushed back-to-back -> out_data 0..9 on consecutive cycles, first at edge+2, in_ready stays 1.
- Backpressure: out_ready=0 with 3 words offered, STAGES=2 -> first 2 accepted, in_ready=0, occupancy=2; out_ready=1 -> words delivered in order, third accepted on the same edge.
- Flush: occupancy=2 with flush=1 and in_valid=1, data 32'h55 -> next edge occupancy=0, out_valid=0, 32'h55 not accepted.
- Random: 1000 cycles of random in_valid/out_ready/flush against a scoreboard -> no loss, no duplication, order kept, occupancy matches model.
- Skid (PIPE_REG_CHAIN_SKID_EN): STAGES=1, out_ready=0, push 2 words -> both accepted, occupancy=2, in_ready registered low; delivery 1 then 2.
